// File: rtl/store_buffer_pkg.sv
// Shared encodings for the store buffer: access sizes, base byte masks,
// default depth and flush FSM states.
package store_buffer_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    localparam int DEFAULT_DEPTH = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            SZ_D:    return MASK_D;
            default: return MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Places a right-justified store into its byte lanes of an 8-byte beat and
// flags accesses that are not naturally aligned to their size.
module store_align
    import store_buffer_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [2:0]    addr_lo,
    input  logic [DW-1:0] st_data,
    input  logic [1:0]    st_size,
    output logic [DW-1:0] wdata,
    output logic [7:0]    wmask,
    output logic          misaligned
);

    // Lane shift, byte-enable generation and natural-alignment check
    always_comb begin
        wdata = st_data << {addr_lo, 3'b000};
        wmask = base_mask(st_size) << addr_lo;
        case (st_size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = (addr_lo[0] != 1'b0);
            SZ_W:    misaligned = (addr_lo[1:0] != 2'b00);
            SZ_D:    misaligned = (addr_lo != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns stores into masked 8-byte beats, queues them and drains
// to memory, with fence-style flush. Optional load-hazard port under STORE_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic [1:0]    st_size,
    input  logic          flush_req,
    output logic          flush_done,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    output logic          misalign_err,
`ifdef STORE_FWD_EN
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
`endif
    output logic          empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [AW-4:0]   addr_q_r [DEPTH];
    logic [DW-1:0]   data_q_r [DEPTH];
    logic [7:0]      mask_q_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic            misalign_err_r;
    logic [DW-1:0]   wdata_s;
    logic [7:0]      wmask_s;
    logic            misaligned_s;
    logic            full_s;
    logic            empty_s;
    logic            enq_s;
    logic            pop_s;
    logic            last_pop_s;
    logic [IW-1:0]   rd_idx_s;

    store_align #(.DW(DW)) u_align (
        .addr_lo    (st_addr[2:0]),
        .st_data    (st_data),
        .st_size    (st_size),
        .wdata      (wdata_s),
        .wmask      (wmask_s),
        .misaligned (misaligned_s)
    );

    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                        (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]);
    assign st_ready   = !full_s && (state_r == ST_RUN);
    assign enq_s      = st_valid && st_ready && !misaligned_s;
    assign pop_s      = !empty_s && mem_wready;
    assign last_pop_s = pop_s && (wr_ptr_r == (rd_ptr_r + PTR_ONE));
    assign rd_idx_s   = rd_ptr_r[IW-1:0];

    assign mem_wvalid   = !empty_s;
    assign mem_waddr    = {addr_q_r[rd_idx_s], 3'b000};
    assign mem_wdata    = data_q_r[rd_idx_s];
    assign mem_wmask    = mask_q_r[rd_idx_s];
    assign empty        = empty_s;
    assign flush_done   = (state_r == ST_DONE);
    assign misalign_err = misalign_err_r;

    // Payload storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (enq_s) begin
            addr_q_r[wr_ptr_r[IW-1:0]] <= st_addr[AW-1:3];
            data_q_r[wr_ptr_r[IW-1:0]] <= wdata_s;
            mask_q_r[wr_ptr_r[IW-1:0]] <= wmask_s;
        end
    end

    // Queue pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Flush sequencing: a pop that empties the queue ends FLUSH without an idle cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_req) state_nxt_s = ST_FLUSH;
                else           state_nxt_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (empty_s || last_pop_s) state_nxt_s = ST_DONE;
                else                       state_nxt_s = ST_FLUSH;
            end
            ST_DONE: state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state and the registered misalignment pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_RUN;
            misalign_err_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            misalign_err_r <= st_valid && st_ready && misaligned_s;
        end
    end

`ifdef STORE_FWD_EN
    logic [PW-1:0] occ_s;
    logic          unused_ld_lo_s;
    assign occ_s          = wr_ptr_r - rd_ptr_r;
    assign unused_ld_lo_s = ^ld_addr[2:0];

    // Compare the load's beat address against every occupied entry
    always_comb begin
        ld_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            ld_hazard = ld_hazard |
                ((PW'(k) < occ_s) &&
                 (addr_q_r[rd_idx_s + IW'(k)] == ld_addr[AW-1:3]));
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [1:0]    st_size;
    logic          flush_req;
    logic          flush_done;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_wmask;
    logic          misalign_err;
    logic          empty;
`ifdef STORE_FWD_EN
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
`endif

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_size      (st_size),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .misalign_err (misalign_err),
`ifdef STORE_FWD_EN
        .ld_addr      (ld_addr),
        .ld_hazard    (ld_hazard),
`endif
        .empty        (empty)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } ent_t;

    ent_t q[$];
    bit   m_flushing = 1'b0;
    bit   m_done     = 1'b0;
    bit   m_mis      = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte placement: lane b receives source byte (b - off)
    function automatic void m_align(input logic [63:0] a, input logic [63:0] d,
                                    input logic [1:0] sz, output logic [63:0] wd,
                                    output logic [7:0] wm, output bit mis);
        int off = int'(a[2:0]);
        int nb  = 1 << sz;
        wd  = 64'h0;
        wm  = 8'h00;
        mis = (off % nb) != 0;
        for (int b = 0; b < 8; b++) begin
            if (b >= off) wd[8*b +: 8] = d[8*(b-off) +: 8];
            if (b >= off && b < off + nb) wm[b] = 1'b1;
        end
    endfunction

    function automatic bit m_ready();
        return (q.size() < DEPTH) && !m_flushing && !m_done;
    endfunction

    // One clock cycle: drive, compare outputs with the model, advance model and clock
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input logic fl, input logic wr);
        logic [63:0] wd;
        logic [7:0]  wm;
        bit          mis, fire, pop, n_done, n_fl;
        st_valid   = v;
        st_addr    = a;
        st_data    = d;
        st_size    = sz;
        flush_req  = fl;
        mem_wready = wr;
`ifdef STORE_FWD_EN
        ld_addr = 64'h8000_0000 + 64'($urandom_range(0, 63));
`endif
        #1;
        check("st_ready", st_ready, m_ready());
        check("mem_wvalid", mem_wvalid, q.size() != 0);
        check("empty", empty, q.size() == 0);
        check("flush_done", flush_done, m_done);
        check("misalign_err", misalign_err, m_mis);
        if (q.size() != 0) begin
            check("mem_waddr", mem_waddr, q[0].addr);
            check("mem_wdata", mem_wdata, q[0].data);
            check("mem_wmask", mem_wmask, q[0].mask);
        end
`ifdef STORE_FWD_EN
        begin
            bit hz = 1'b0;
            foreach (q[i]) if (q[i].addr[63:3] == ld_addr[63:3]) hz = 1'b1;
            check("ld_hazard", ld_hazard, hz);
        end
`endif
        fire = v && m_ready();
        pop  = (q.size() != 0) && wr;
        m_align(a, d, sz, wd, wm, mis);
        if (pop) void'(q.pop_front());
        if (fire && !mis) q.push_back('{a & ~64'h7, wd, wm});
        n_done = m_flushing && (q.size() == 0);
        n_fl   = m_flushing ? (q.size() != 0) : (fl && !m_done);
        m_mis      = fire && mis;
        m_done     = n_done;
        m_flushing = n_fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wr);
        step(1'b0, 64'h0, 64'h0, SZ_B, 1'b0, wr);
    endtask

    initial begin
        rst        = 1'b1;
        st_valid   = 1'b0;
        st_addr    = 64'h0;
        st_data    = 64'h0;
        st_size    = SZ_B;
        flush_req  = 1'b0;
        mem_wready = 1'b0;
`ifdef STORE_FWD_EN
        ld_addr = 64'h0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_st_ready", st_ready, 1'b1);
        check("rst_wvalid", mem_wvalid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_misalign", misalign_err, 1'b0);
        rst = 1'b0;

        // Byte store into lane 5
        step(1'b1, 64'h8000_0005, 64'hAB, SZ_B, 1'b0, 1'b1);
        check("t1_waddr", mem_waddr, 64'h8000_0000);
        check("t1_wdata", mem_wdata, 64'h0000_AB00_0000_0000);
        check("t1_wmask", mem_wmask, 8'h20);

        // Word in upper half, then a double
        step(1'b1, 64'h8000_0004, 64'hDEAD_BEEF, SZ_W, 1'b0, 1'b1);
        check("t2_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
        check("t2_wmask", mem_wmask, 8'hF0);
        step(1'b1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, SZ_D, 1'b0, 1'b1);
        check("t2_dmask", mem_wmask, 8'hFF);
        check("t2_daddr", mem_waddr, 64'h8000_0008);
        idle(1'b1);

        // Fill with memory stalled, then drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 64'h8000_0100 + 64'(8*i), 64'(i + 1), SZ_D, 1'b0, 1'b0);
        check("t3_full_ready", st_ready, 1'b0);
        check("t3_wvalid", mem_wvalid, 1'b1);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("t3_empty", empty, 1'b1);

        // Misaligned half is consumed but dropped
        step(1'b1, 64'h8000_0003, 64'h1234, SZ_H, 1'b0, 1'b1);
        check("t4_misalign", misalign_err, 1'b1);
        check("t4_wvalid", mem_wvalid, 1'b0);
        idle(1'b1);

        // Flush with three entries and a toggling memory
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h8000_0200 + 64'(8*i), 64'(i + 7), SZ_D, 1'b0, 1'b0);
        step(1'b0, 64'h0, 64'h0, SZ_B, 1'b1, 1'b1);
        check("t5_flush_ready", st_ready, 1'b0);
        for (int i = 0; i < 8; i++) idle(i[0] == 1'b0 ? 1'b0 : 1'b1);
        // Flush while already empty
        step(1'b0, 64'h0, 64'h0, SZ_B, 1'b1, 1'b1);
        idle(1'b1);
        check("t5_empty_flush_done", flush_done, 1'b1);
        idle(1'b1);
        check("t5_ready_after", st_ready, 1'b1);

        // Asynchronous reset mid-drain
        step(1'b1, 64'h8000_0300, 64'h55, SZ_B, 1'b0, 1'b0);
        step(1'b1, 64'h8000_0308, 64'h66, SZ_B, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_wvalid", mem_wvalid, 1'b0);
        check("t6_empty", empty, 1'b1);
        q.delete();
        m_flushing = 1'b0;
        m_done     = 1'b0;
        m_mis      = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7,
                 64'h8000_0000 + 64'($urandom_range(0, 63)),
                 {$urandom, $urandom},
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart of the execute-stage load path; sits between the execute stage and the data-memory write port.
- Accepts store requests (address, data, size) over a valid/ready handshake.
- Aligns each store into an 8-byte beat with a byte mask and queues it in a small FIFO.
- Drains the FIFO to memory over a valid/ready write port; supports a fence-style flush.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.
- AW, 64, address width.
- DW, 64, store data width (one beat).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- st_valid  in  1  store request valid
- st_ready  out  1  store request accepted this cycle when high together with st_valid
- st_addr  in  AW  byte address
- st_data  in  DW  store data, right-justified
- st_size  in  2  00=byte, 01=half, 10=word, 11=double
- flush_req  in  1  one-cycle pulse: drain everything, then report
- flush_done  out  1  one-cycle pulse when flush completes
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  memory accepts beat
- mem_waddr  out  AW  8-byte-aligned address {st_addr[AW-1:3],3'b000}
- mem_wdata  out  DW  lane-aligned data
- mem_wmask  out  8  byte-enable mask
- misalign_err  out  1  one-cycle pulse, registered
- empty  out  1  FIFO holds no entries

Behaviour:
Reset (asynchronous):
- Pointers, count and state are cleared; state = RUN.
- Outputs at reset: st_ready=1, mem_wvalid=0, empty=1, flush_done=0, misalign_err=0.
- Reset mid-transfer discards all queued stores.

Alignment (combinational, at enqueue):
- off = st_addr[2:0].
- wdata = st_data << (8*off), truncated to DW.
- Base mask by size: byte 0x01, half 0x03, word 0x0F, double 0xFF.
- wmask = base mask << off.
- Misaligned when:
  - half and off[0] != 0;
  - word and off[1:0] != 0;
  - double and off != 0.
- A misaligned store is handshaken (consumed) but not enqueued; misalign_err pulses in the following cycle.

FIFO:
- Pointers are log2(DEPTH)+1 bits; full when MSBs differ and low bits are equal; wrap is natural.
- st_ready = !full && state==RUN; it is a function of registered state only, with no full-time bypass.
- Simultaneous enqueue and dequeue keeps count unchanged; both pointers advance.
- Enqueue is visible on mem_wvalid one cycle later at the earliest (no combinational pass-through).

Drain:
- mem_wvalid = !empty.
- mem_waddr, mem_wdata and mem_wmask come from the head entry and hold stable until mem_wready.
- The head pops on mem_wvalid && mem_wready.
- mem_wvalid never drops without a handshake.

FSM:
- RUN:
  - flush_req moves to FLUSH.
  - A store handshaken in the same cycle as flush_req is still enqueued.
- FLUSH:
  - st_ready=0; the FIFO keeps draining.
  - When empty (including already empty on entry), move to DONE.
- DONE:
  - flush_done=1 for exactly one cycle; next state is RUN.
- flush_req while in FLUSH or DONE is ignored.

Optional Feature:
Macro STORE_FWD_EN.
- When defined:
  - Adds input ld_addr (AW) and output ld_hazard (1).
  - ld_hazard is combinational: high if any valid entry's 8-byte-aligned address equals {ld_addr[AW-1:3],3'b000}.
  - The pipeline stalls the load on ld_hazard.
- When undefined:
  - Neither port exists.
  - The pipeline must flush the buffer before loads that may alias.

Decomposition:
- Shared defines header holds:
  - size encodings (SZ_B/SZ_H/SZ_W/SZ_D);
  - base-mask constants;
  - default DEPTH;
  - FSM state encodings (RUN, FLUSH, DONE).
- One sub-module, store_align: pure combinational st_addr/st_data/st_size to wdata/wmask/misaligned.
- Instantiated once in store_buffer.

Test Plan:
1. Byte store: addr 0x80000005, data 0xAB, mem_wready=1 -> next cycle mem_waddr=0x80000000, wdata=0x0000AB0000000000, wmask=0x20.
2. Word store: addr 0x80000004, data 0xDEADBEEF -> wdata=0xDEADBEEF00000000, wmask=0xF0. Double at addr 0x80000008 -> wmask=0xFF.
3. Fill: mem_wready=0, push 4 stores -> st_ready=0 after the 4th; mem_wvalid=1 with head stable. Release mem_wready -> in-order drain over 4 cycles, then empty=1.
4. Misaligned half at addr 0x80000003 -> handshake completes, misalign_err=1 next cycle, no mem_wvalid, count unchanged.
5. Flush with 3 entries and mem_wready toggling 1/0 -> st_ready=0 during FLUSH; flush_done pulses one cycle after the last pop, then st_ready=1. Flush when empty -> flush_done two cycles after flush_req.
6. Assert rst mid-drain (2 entries queued) -> mem_wvalid=0 and empty=1 immediately (asynchronously); no further writes issue.
